// File: rtl/risc16_sequencer.sv
// rtl/risc16_sequencer.sv - multi-cycle control FSM for the RISC-16 datapath
module risc16_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic [6:0] imm7,
  input  logic       alu_eq,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_sel,
  output logic       gpr_write_en,
  output logic [1:0] wb_sel,
  output logic       retired,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  // Counter value seen in the last req cycle allowed before a timeout.
  localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] wait_cnt;
  logic          req_cycle;
  logic          timeout;

  assign req_cycle = (state == S_FETCH) || (state == S_MEM);
  // An ack on the limit cycle still completes the access.
  assign timeout   = req_cycle && !mem_ack && (wait_cnt == LAST_WAIT);

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Wait counter: counts unacknowledged req cycles, zero everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       wait_cnt <= '0;
    else if (!req_cycle || mem_ack) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + 1'b1;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack)      state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_SW, OP_LW: state_nxt = S_MEM;
          OP_BEQ:       state_nxt = S_FETCH;
          OP_JALR:      state_nxt = (imm7 == 7'd0) ? S_FETCH : S_HALT;
          default:      state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ack)      state_nxt = (opcode == OP_SW) ? S_FETCH : S_WB;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes from state and opcode; ack qualifies completion strobes.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_sel       = 2'b00;
    gpr_write_en = 1'b0;
    wb_sel       = 2'b00;
    retired      = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
      end
      S_EXEC: begin
        if (opcode == OP_BEQ) begin
          pc_load = 1'b1;
          pc_sel  = alu_eq ? 2'b01 : 2'b00;
          retired = 1'b1;
        end else if (opcode == OP_JALR && imm7 == 7'd0) begin
          gpr_write_en = 1'b1;
          wb_sel       = 2'b10;
          pc_load      = 1'b1;
          pc_sel       = 2'b10;
          retired      = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_SW);
        if (opcode == OP_SW && mem_ack) begin
          pc_load = 1'b1;
          retired = 1'b1;
        end
      end
      S_WB: begin
        gpr_write_en = 1'b1;
        pc_load      = 1'b1;
        retired      = 1'b1;
        wb_sel       = (opcode == OP_LW) ? 2'b01 : 2'b00;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc16_sequencer.sv
// tb/tb_risc16_sequencer.sv - randomized trace-based bench for risc16_sequencer
module tb_risc16_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [2:0] opcode;
  logic [6:0] imm7;
  logic       alu_eq;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_load, pc_load;
  logic [1:0] pc_sel, wb_sel;
  logic       gpr_write_en, retired, halted, fault;

  int checks = 0;
  int errors = 0;

  risc16_sequencer #(.MEM_TIMEOUT(4), .TW(3)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .imm7(imm7),
    .alu_eq(alu_eq), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .gpr_write_en(gpr_write_en), .wb_sel(wb_sel), .retired(retired),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        run;
    logic [2:0]  op;
    logic [6:0]  imm;
    logic        eq;
    logic [12:0] o;
  } step_t;

  step_t      q[$];
  logic [2:0] cur_op;
  logic [6:0] cur_imm;
  logic       cur_eq;

  function automatic logic [12:0] mk(input logic req, we, as_, irl, pcl,
                                     input logic [1:0] pcs, input logic gw,
                                     input logic [1:0] wbs, input logic ret, h, f);
    return {req, we, as_, irl, pcl, pcs, gw, wbs, ret, h, f};
  endfunction

  function automatic logic [12:0] observed();
    return {mem_req, mem_we, addr_sel, ir_load, pc_load, pc_sel,
            gpr_write_en, wb_sel, retired, halted, fault};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_r(input logic ack, input logic r, input logic [12:0] o);
    q.push_back({ack, r, cur_op, cur_imm, cur_eq, o});
  endtask

  // run is ignored outside IDLE, so it is randomized on every other step.
  task automatic push(input logic ack, input logic [12:0] o);
    push_r(ack, rbit(), o);
  endtask

  // Expected per-cycle trace of one instruction, from the instruction's rules.
  task automatic gen_instr(input logic [2:0] op, input logic [6:0] imm,
                           input logic eq, input int wf, input int wm);
    cur_op = op; cur_imm = imm; cur_eq = eq;
    for (int i = 0; i < wf; i++) push(1'b0, mk(1,0,0,0,0,2'b00,0,2'b00,0,0,0));
    push(1'b1, mk(1,0,0,1,0,2'b00,0,2'b00,0,0,0));
    push(rbit(), 13'd0);
    case (op)
      3'd4: begin
        push(rbit(), 13'd0);
        for (int i = 0; i < wm; i++) push(1'b0, mk(1,1,1,0,0,2'b00,0,2'b00,0,0,0));
        push(1'b1, mk(1,1,1,0,1,2'b00,0,2'b00,1,0,0));
      end
      3'd5: begin
        push(rbit(), 13'd0);
        for (int i = 0; i < wm; i++) push(1'b0, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0));
        push(1'b1, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0));
        push(rbit(), mk(0,0,0,0,1,2'b00,1,2'b01,1,0,0));
      end
      3'd6: push(rbit(), mk(0,0,0,0,1, eq ? 2'b01 : 2'b00, 0,2'b00,1,0,0));
      3'd7: begin
        if (imm == 7'd0) push(rbit(), mk(0,0,0,0,1,2'b10,1,2'b10,1,0,0));
        else             push(rbit(), 13'd0);
      end
      default: begin
        push(rbit(), 13'd0);
        push(rbit(), mk(0,0,0,0,1,2'b00,1,2'b00,1,0,0));
      end
    endcase
  endtask

  // Drive each step just after a rising edge, compare on the falling edge.
  task automatic play(input string tag);
    step_t s;
    int    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      run = s.run; opcode = s.op; imm7 = s.imm; alu_eq = s.eq; mem_ack = s.ack;
      @(negedge clk);
      checks++;
      assert (observed() === s.o) else begin
        errors++;
        $error("FAIL %s step %0d: observed %b expected %b", tag, n, observed(), s.o);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = 3'd0; imm7 = 7'd0; alu_eq = 1'b0;
    @(posedge clk); #1;
    checks++;
    assert (observed() === 13'd0) else begin
      errors++;
      $error("FAIL reset_outputs: observed %b expected %b", observed(), 13'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] op;
    logic [6:0] imm;

    // Reset state, then async reset in the middle of an LW memory wait.
    do_reset();
    push_r(rbit(), 1'b1, 13'd0);
    cur_op = 3'd5; cur_imm = 7'd0; cur_eq = 1'b0;
    push(1'b1, mk(1,0,0,1,0,2'b00,0,2'b00,0,0,0));
    push(rbit(), 13'd0);
    push(rbit(), 13'd0);
    push(1'b0, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0));
    push(1'b0, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0));
    play("lw_before_rst");
    mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    assert (observed() === 13'd0) else begin
      errors++;
      $error("FAIL rst_mid_mem: observed %b expected %b", observed(), 13'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    push_r(rbit(), 1'b0, 13'd0);
    push_r(rbit(), 1'b0, 13'd0);
    push_r(rbit(), 1'b1, 13'd0);
    gen_instr(3'd0, 7'd5, 1'b0, 0, 0);
    play("idle_after_rst_add");

    // Directed: LW with 3 waits in MEM, fetch acked on the limit cycle,
    // BEQ taken/not taken, JALR link, SW.
    gen_instr(3'd5, 7'd1, 1'b0, 0, 3);  play("lw_wait3");
    gen_instr(3'd1, 7'd9, 1'b1, 3, 0);  play("fetch_ack_at_limit");
    gen_instr(3'd6, 7'd2, 1'b1, 0, 0);  play("beq_taken");
    gen_instr(3'd6, 7'd2, 1'b0, 0, 0);  play("beq_not_taken");
    gen_instr(3'd7, 7'd0, 1'b0, 0, 0);  play("jalr_link");
    gen_instr(3'd4, 7'd3, 1'b0, 1, 2);  play("sw_waits");

    // Random program with random memory latency up to the limit.
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      imm = (op == 3'd7) ? 7'd0 : 7'($urandom_range(0, 127));
      gen_instr(op, imm, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
      play("random_instr");
    end

    // JALR with nonzero imm7 halts; halted stays, no further requests.
    gen_instr(3'd7, 7'd1, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) push(rbit(), mk(0,0,0,0,0,2'b00,0,2'b00,0,1,0));
    play("halt_sticky");

    // Fetch timeout: four unacknowledged req cycles, then sticky fault.
    do_reset();
    push_r(rbit(), 1'b1, 13'd0);
    for (int i = 0; i < 4; i++) push(1'b0, mk(1,0,0,0,0,2'b00,0,2'b00,0,0,0));
    for (int i = 0; i < 5; i++) push(rbit(), mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1));
    play("fetch_timeout");

    // MEM timeout on an SW data phase.
    do_reset();
    push_r(rbit(), 1'b1, 13'd0);
    cur_op = 3'd4; cur_imm = 7'd0; cur_eq = 1'b0;
    push(1'b1, mk(1,0,0,1,0,2'b00,0,2'b00,0,0,0));
    push(rbit(), 13'd0);
    push(rbit(), 13'd0);
    for (int i = 0; i < 4; i++) push(1'b0, mk(1,1,1,0,0,2'b00,0,2'b00,0,0,0));
    for (int i = 0; i < 3; i++) push(rbit(), mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1));
    play("mem_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
